sll_share_arbiter: RTL and testbench
====================================

# sll_share_arbiter

Shares one constant-time log-step left shifter (`SllLog`) between `NREQ` requesters. It arbitrates round-robin, feeds the winner's operands to the shifter at each shifter restart slot, tags the job with the requester id, and buffers results in a 2-entry output FIFO with valid/ready backpressure. It sits between modmul front-end units and the single shifter instance, so shifter area is not replicated.

## Interface
- `LOGSIZE`, 8, log2 of operand width; `SIZE = 1<<LOGSIZE`.
- `NREQ`, 4, number of requesters, ≥2.
- `clock`  in  1  single clock, all state on posedge.
- `reset`  in  1  synchronous, active-high. Also drives the shifter's reset.
- `req_valid`  in  NREQ  per-requester job request.
- `req_in`  in  NREQ*SIZE  operand; slice k belongs to requester k.
- `req_shift`  in  NREQ*LOGSIZE  shift amount per requester.
- `req_ready`  out  NREQ  one-hot grant; the job is accepted in the cycle where `valid && ready`.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_data`  out  SIZE  `in << shift`, truncated to SIZE.
- `resp_id`  out  IDW  index of the requester that owns the result.

## Operation
- The shifter is free-running with a period of SLOT = LOGSIZE+1 cycles. Its `done` pulses for 1 cycle, and at the closing edge of that cycle it samples `in`/`shift` and restarts.
- Load cycle is the cycle with shifter `done==1`. Only in a load cycle can `req_ready` be non-zero.
- In a load cycle:
  - If `flight_v`, push {`flight_id`, shifter `out`} into the FIFO.
  - Compute `cnt_next = cnt + push - pop`.
  - If `cnt_next ≤ 1`, pick the first valid requester, searching circularly from `last+1`. Assert its `req_ready`, drive its operands to the shifter, and set `flight_v=1`, `flight_id=winner`, `last=winner`.
  - Otherwise, or if there is no valid request, drive shifter inputs to 0 and set `flight_v=0` (idle slot).
- `req_ready` is combinational from the `done`, FIFO-count and `req_valid` state, and never depends on `resp_ready` within the same cycle other than through `pop`.
- Requesters hold `req_valid` and operands stable until granted. Dropping `req_valid` before the grant is legal; that request simply loses eligibility.
- FIFO is 2 entries. Pop happens when `resp_valid && resp_ready`. Simultaneous push and pop is allowed when count is 1 or 2. Push never targets a full FIFO; this is guaranteed by the `cnt_next ≤ 1` grant rule.
- Arithmetic: `resp_data = (req_in << req_shift) mod 2^SIZE`. Shift 0 passes the operand through unchanged.

## Timing
- Reset values:
  - `req_ready=0`, `resp_valid=0`, `resp_data=0`, `resp_id=0`.
  - FIFO empty, `flight_v=0`, `last=NREQ-1` (requester 0 wins first).
- The first load cycle occurs LOGSIZE cycles after the last reset-high edge. Load cycles then repeat every SLOT cycles.
- Latency:
  - A job granted in cycle T has its result pushed at cycle T+SLOT.
  - `resp_valid` rises at T+SLOT+1 if the FIFO was empty.
- Throughput is 1 job per SLOT cycles with no gap between consecutive grants.
- Backpressure: with `resp_ready=0`, at most 2 results are buffered. Further load cycles are idle until a pop, and no result is ever lost.
- Reset mid-job: the in-flight job and buffered results are discarded with no `resp_valid`. Arbitration restarts from requester 0.
- `resp_data`/`resp_id` hold stable while `resp_valid && !resp_ready`.

## Structure
- Package `sll_arb_pkg` holds `IDW = $clog2(NREQ)`, `SLOT = LOGSIZE+1`, and a packed result typedef {id, data}.
- The block instantiates the existing `SllLog` unmodified, with `clock` and `reset` shared.
- One new sub-module, `sll_rr_pick`: a combinational round-robin picker with inputs `valid[NREQ]` and `last` and outputs a one-hot grant plus the index.
- FIFO and flight registers are inline.

## Test plan
All scenarios use LOGSIZE=4 (SIZE=16, SLOT=5) and NREQ=4.
- Single job: release reset; req0 holds `in=0x0001`, `shift=5` → `req_ready[0]` asserts 4 cycles after reset release; `resp_valid` 6 cycles later with `resp_data=0x0020`, `resp_id=0`.
- Edge shifts: req1 sends `0xFFFF`, shift 15 → result `0x8000`. Then `0xABCD`, shift 0 → result `0xABCD`, id 1.
- Fairness: all 4 requesters continuously valid with distinct operands, `resp_ready=1` → grants 0,1,2,3,0 exactly 5 cycles apart; responses return in the same order with correct data.
- Backpressure: all valid, `resp_ready=0` → exactly 2 grants, then `req_ready` stays 0 and the FIFO holds 2 entries unchanged. Raising `resp_ready` for 1 cycle pops 1 entry, and the next load cycle grants again.
- Reset mid-flight: assert reset 2 cycles after a grant to req2 → no response for that job; the next grant goes to req0 (if valid) LOGSIZE cycles after release.
- Idle/drop: req3 drops `req_valid` before its grant → that slot is idle; `flight_v=0`; no spurious `resp_valid`.

Source files
------------

// File: rtl/sll_arb_pkg.sv
// rtl/sll_arb_pkg.sv - shared constants, result type and width helpers for the shifter arbiter
package sll_arb_pkg;

  localparam int DEF_LOGSIZE = 8;
  localparam int DEF_NREQ    = 4;
  localparam int IDW         = $clog2(DEF_NREQ);
  localparam int SLOT        = DEF_LOGSIZE + 1;

  typedef struct packed {
    logic [IDW-1:0]               id;
    logic [(1<<DEF_LOGSIZE)-1:0]  data;
  } sll_result_t;

  // Requester-id width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/SllLog.sv
// rtl/SllLog.sv - free-running log-step left shifter, one stage per cycle, restarts after done
module SllLog #(
  parameter int LOGSIZE = 8,
  localparam int SIZE = 1 << LOGSIZE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SIZE-1:0]    in,
  input  logic [LOGSIZE-1:0] shift,
  output logic [SIZE-1:0]    out,
  output logic               done
);

  localparam int SW = $clog2(LOGSIZE + 1);

  logic [SW-1:0]      step_q, step_d;
  logic [SIZE-1:0]    acc_q, acc_d;
  logic [LOGSIZE-1:0] sh_q, sh_d;

  assign done = (step_q == SW'(LOGSIZE));
  assign out  = acc_q;

  // Stage k consumes shift bit k; the amount register is shifted right so bit 0 is always current.
  always_comb begin
    step_d = step_q + SW'(1);
    acc_d  = acc_q;
    sh_d   = sh_q >> 1;
    if (done) begin
      step_d = '0;
      acc_d  = in;
      sh_d   = shift;
    end else if (sh_q[0]) begin
      acc_d = acc_q << (1 << step_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_q <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
    end else begin
      step_q <= step_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
    end
  end

endmodule

// File: rtl/sll_rr_pick.sv
// rtl/sll_rr_pick.sv - combinational round-robin picker searching circularly from last+1
module sll_rr_pick
  import sll_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!any && valid[cand]) begin
        any        = 1'b1;
        idx        = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sll_share_arbiter.sv
// rtl/sll_share_arbiter.sv - round-robin sharing of one SllLog shifter with a 2-entry result FIFO
module sll_share_arbiter
  import sll_arb_pkg::*;
#(
  parameter int LOGSIZE = DEF_LOGSIZE,
  parameter int NREQ    = DEF_NREQ,
  localparam int SIZE   = 1 << LOGSIZE,
  localparam int IW     = id_width(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SIZE-1:0]    req_in,
  input  logic [NREQ*LOGSIZE-1:0] req_shift,
  output logic [NREQ-1:0]         req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [SIZE-1:0]         resp_data,
  output logic [IW-1:0]           resp_id
);

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [SIZE-1:0] data;
  } res_t;

  logic               sh_done;
  logic [SIZE-1:0]    sh_out, sh_in;
  logic [LOGSIZE-1:0] sh_amt;
  logic [NREQ-1:0]    pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic          flight_v_q, flight_v_d;
  logic [IW-1:0] flight_id_q, flight_id_d;
  logic [IW-1:0] last_q, last_d;
  res_t          mem_q [2];
  res_t          mem_d [2];
  logic          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop, load_ok;

  sll_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  SllLog #(.LOGSIZE(LOGSIZE)) u_shift (
    .clock (clock),
    .reset (reset),
    .in    (sh_in),
    .shift (sh_amt),
    .out   (sh_out),
    .done  (sh_done)
  );

  assign resp_valid = (cnt_q != 2'd0);
  assign resp_data  = mem_q[rd_ptr_q].data;
  assign resp_id    = mem_q[rd_ptr_q].id;

  always_comb begin
    push  = sh_done & flight_v_q;
    pop   = resp_valid & resp_ready;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    // Granting only when at most one entry remains keeps the next push from hitting a full FIFO.
    load_ok   = sh_done & ~reset & pick_any & (cnt_d <= 2'd1);
    req_ready = load_ok ? pick_grant : '0;
    sh_in     = load_ok ? req_in[int'(pick_idx)*SIZE +: SIZE] : '0;
    sh_amt    = load_ok ? req_shift[int'(pick_idx)*LOGSIZE +: LOGSIZE] : '0;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{id: flight_id_q, data: sh_out};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    flight_v_d  = flight_v_q;
    flight_id_d = flight_id_q;
    last_d      = last_q;
    if (sh_done) begin
      flight_v_d = load_ok;
      if (load_ok) begin
        flight_id_d = pick_idx;
        last_d      = pick_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flight_v_q  <= 1'b0;
      flight_id_q <= '0;
      last_q      <= IW'(NREQ - 1);
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      flight_v_q  <= flight_v_d;
      flight_id_q <= flight_id_d;
      last_q      <= last_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sll_share_arbiter.sv
// tb/tb_sll_share_arbiter.sv - directed self-checking bench for sll_share_arbiter (LOGSIZE=4, NREQ=4)
module tb_sll_share_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_in = '0;
  logic [15:0] req_shift = '0;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic [1:0]  resp_id;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_tbl [4] = '{16'h2468, 16'h0008, 16'h0F00, 16'hFF00};

  sll_share_arbiter #(.LOGSIZE(4), .NREQ(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_in     (req_in),
    .req_shift  (req_shift),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic [15:0] v, input logic [3:0] s);
    req_in[k*16 +: 16]  = v;
    req_shift[k*4 +: 4] = s;
  endtask

  task automatic set_fair_ops();
    set_req(0, 16'h1234, 4'd1);
    set_req(1, 16'h8001, 4'd3);
    set_req(2, 16'h00F0, 4'd4);
    set_req(3, 16'hFFFF, 4'd8);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int budget, input logic [3:0] exp_mask);
    #1;
    for (int i = 0; i < budget; i++) begin
      if (req_ready != 4'd0) break;
      tick();
    end
    check("grant_wait", 32'(req_ready), 32'(exp_mask));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with a request pending so ready gating is exercised.
    req_valid = 4'b1111;
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);

    // Single job: grant 4 cycles after release, result 6 cycles after grant.
    req_valid = 4'b0001;
    set_req(0, 16'h0001, 4'd5);
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("s1_ready", 32'(req_ready), (c == 4) ? 32'h1 : 32'h0);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req_valid = 4'b0000;
      check("s1_resp_valid", 32'(resp_valid), 32'(c == 6));
    end
    check("s1_data", 32'(resp_data), 32'h0020);
    check("s1_id", 32'(resp_id), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("s1_popped", 32'(resp_valid), 32'd0);

    // Edge shifts on requester 1, back to back.
    set_req(1, 16'hFFFF, 4'd15);
    req_valid  = 4'b0010;
    resp_ready = 1'b1;
    wait_grant(8, 4'b0010);
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) set_req(1, 16'hABCD, 4'd0);
      if (c == 6) req_valid = 4'b0000;
      if (c <= 10) check("s2_ready", 32'(req_ready), (c == 5) ? 32'h2 : 32'h0);
      check("s2_resp_valid", 32'(resp_valid), 32'(c == 6 || c == 11));
      if (c == 6) begin
        check("s2_data_max", 32'(resp_data), 32'h8000);
        check("s2_id_max", 32'(resp_id), 32'd1);
      end
      if (c == 11) begin
        check("s2_data_zero", 32'(resp_data), 32'hABCD);
        check("s2_id_zero", 32'(resp_id), 32'd1);
      end
    end

    // Fairness: all valid, grants 0,1,2,3,0 five cycles apart, in-order responses.
    set_fair_ops();
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    do_reset();
    wait_grant(8, 4'b0001);
    for (int c = 1; c <= 28; c++) begin
      tick();
      if (c == 21) req_valid = 4'b0000;
      check("s3_ready", 32'(req_ready),
            (c % 5 == 0 && c <= 20) ? 32'(4'b0001 << ((c / 5) % 4)) : 32'h0);
      check("s3_resp_valid", 32'(resp_valid), 32'(c >= 6 && (c - 6) % 5 == 0));
      if (c >= 6 && (c - 6) % 5 == 0) begin
        check("s3_data", 32'(resp_data), 32'(exp_tbl[((c - 6) / 5) % 4]));
        check("s3_id", 32'(resp_id), 32'(((c - 6) / 5) % 4));
      end
    end

    // Backpressure: two grants, then idle slots until a single pop frees room.
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    do_reset();
    wait_grant(8, 4'b0001);
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (c == 28) resp_ready = 1'b0;
      if (c == 31) req_valid = 4'b0000;
      check("s4_ready", 32'(req_ready),
            (c == 5) ? 32'h2 : (c == 30) ? 32'h4 : 32'h0);
      check("s4_resp_valid", 32'(resp_valid), 32'(c >= 6));
      if (c >= 6) begin
        check("s4_data", 32'(resp_data), (c <= 27) ? 32'h2468 : 32'h0008);
        check("s4_id", 32'(resp_id), (c <= 27) ? 32'd0 : 32'd1);
      end
      if (c == 20) check("s4_fifo_full", 32'(dut.cnt_q), 32'd2);
      if (c == 27) resp_ready = 1'b1;
    end
    resp_ready = 1'b1;
    tick();
    tick();
    tick();
    check("s4_drained", 32'(resp_valid), 32'd0);

    // Reset two cycles after a grant to req2, then an idle slot after req3 drops its request.
    req_valid = 4'b0100;
    do_reset();
    wait_grant(8, 4'b0100);
    tick();
    req_valid = 4'b0000;
    tick();
    reset     = 1'b1;
    req_valid = 4'b1101;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 5)  req_valid = 4'b0000;
      if (c == 12) req_valid = 4'b1000;
      if (c == 13) req_valid = 4'b0000;
      check("s5_ready", 32'(req_ready), (c == 4) ? 32'h1 : 32'h0);
      check("s5_resp_valid", 32'(resp_valid), 32'(c == 10));
      if (c == 10) begin
        check("s5_data", 32'(resp_data), 32'h2468);
        check("s5_id", 32'(resp_id), 32'd0);
      end
      if (c == 6)  check("s5_flight_busy", 32'(dut.flight_v_q), 32'd1);
      if (c == 15) check("s6_flight_idle", 32'(dut.flight_v_q), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
